// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-side word packer.
// Holds the packer state encoding and the byte-lane keep-mask helper.
package fifo_pkg;

    typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} pack_state_t;

    localparam int DATA_W    = 8;
    localparam int MAX_BYTES = 8;

    // Mask with the low n lanes set; n at or above MAX_BYTES yields all ones.
    function automatic logic [MAX_BYTES-1:0] keep_mask(input int unsigned n);
        logic [MAX_BYTES-1:0] one_v;
        one_v = {{(MAX_BYTES-1){1'b0}}, 1'b1};
        if (n >= 32'(MAX_BYTES)) begin
            keep_mask = {MAX_BYTES{1'b1}};
        end else begin
            keep_mask = (one_v << n) - one_v;
        end
    endfunction

endpackage

// File: rtl/fifo_word_packer_props.sv
// Interface properties for fifo_word_packer: FIFO read safety and output hold.
// Instantiated alongside the packer wherever assertions are wanted.
module fifo_word_packer_props #(
    parameter int WORD_W = 32
) (
    input logic              clk,
    input logic              rst_,
    input logic              fifo_empty,
    input logic              fifo_read,
    input logic              out_valid,
    input logic              out_ready,
    input logic [WORD_W-1:0] out_data
);

    a_no_read_on_empty: assert property (@(posedge clk) disable iff (!rst_)
        !(fifo_read && fifo_empty));

    a_hold_under_backpressure: assert property (@(posedge clk) disable iff (!rst_)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

endmodule

// File: rtl/fifo_word_packer.sv
// Drains bytes from an 8-bit FIFO and packs them, first byte at the LSBs, into
// words on a valid/ready bus; flush emits a partial word with a lane keep mask.
module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter int DATA_W         = fifo_pkg::DATA_W,
    parameter int BYTES_PER_WORD = 4
) (
    input  logic                             clk,
    input  logic                             rst_,
    input  logic                             fifo_empty,
    input  logic [DATA_W-1:0]                fifo_data_out,
    output logic                             fifo_read,
    input  logic                             flush,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_W*BYTES_PER_WORD-1:0] out_data,
    output logic [BYTES_PER_WORD-1:0]        out_keep,
    output logic                             out_last
);

    localparam int WORD_W = DATA_W * BYTES_PER_WORD;
    localparam int CNT_W  = $clog2(BYTES_PER_WORD + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BYTES_PER_WORD);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    pack_state_t                state_q, state_d;
    logic [CNT_W-1:0]           issued_q, issued_d;
    logic [CNT_W-1:0]           captured_q, captured_d;
    logic                       rd_pend_q, rd_pend_d;
    logic                       flush_pend_q, flush_pend_d;
    logic                       out_valid_q, out_valid_d;
    logic [WORD_W-1:0]          out_data_q, out_data_d;
    logic [BYTES_PER_WORD-1:0]  out_keep_q, out_keep_d;
    logic                       out_last_q, out_last_d;
    logic                       fifo_read_s;
    logic                       flush_hit_s;

    // Read strobe: only while filling, with room in the word and data in the FIFO.
    always_comb begin
        fifo_read_s = 1'b0;
        if (state_q == FILL) begin
            fifo_read_s = !fifo_empty && (issued_q < CNT_FULL) && !(flush_pend_q && fifo_empty);
        end else begin
            fifo_read_s = 1'b0;
        end
    end

    // Next-state logic for the FSM, lane counters, flush tracking and output word.
    always_comb begin
        state_d      = state_q;
        issued_d     = issued_q;
        captured_d   = captured_q;
        rd_pend_d    = rd_pend_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_keep_d   = out_keep_q;
        out_last_d   = out_last_q;
        flush_hit_s  = flush_pend_q || flush;
        flush_pend_d = flush_hit_s;

        case (state_q)
            FILL: begin
                rd_pend_d = fifo_read_s;
                if (fifo_read_s) begin
                    issued_d = issued_q + CNT_ONE;
                end else begin
                    issued_d = issued_q;
                end

                if (rd_pend_q) begin
                    out_data_d[32'(captured_q)*DATA_W +: DATA_W] = fifo_data_out;
                    captured_d = captured_q + CNT_ONE;
                    if (captured_q == CNT_FULL - CNT_ONE) begin
                        state_d     = DRAIN;
                        out_valid_d = 1'b1;
                        out_keep_d  = BYTES_PER_WORD'(keep_mask(32'(BYTES_PER_WORD)));
                        out_last_d  = 1'b0;
                        // A pending flush survives a full word only if bytes remain behind it.
                        if (fifo_empty) begin
                            flush_pend_d = 1'b0;
                        end else begin
                            flush_pend_d = flush_hit_s;
                        end
                    end else begin
                        state_d = FILL;
                    end
                end else if (flush_pend_q && fifo_empty) begin
                    flush_pend_d = 1'b0;
                    if (captured_q != {CNT_W{1'b0}}) begin
                        state_d     = DRAIN;
                        out_valid_d = 1'b1;
                        out_keep_d  = BYTES_PER_WORD'(keep_mask(32'(captured_q)));
                        out_last_d  = 1'b1;
                    end else begin
                        state_d = FILL;
                    end
                end else begin
                    state_d = FILL;
                end
            end

            DRAIN: begin
                rd_pend_d = 1'b0;
                if (out_ready) begin
                    state_d     = FILL;
                    out_valid_d = 1'b0;
                    issued_d    = {CNT_W{1'b0}};
                    captured_d  = {CNT_W{1'b0}};
                    out_data_d  = {WORD_W{1'b0}};
                    out_keep_d  = {BYTES_PER_WORD{1'b0}};
                    out_last_d  = 1'b0;
                end else begin
                    state_d = DRAIN;
                end
            end

            default: begin
                state_d = FILL;
            end
        endcase
    end

    // State and output registers; reset discards any partially packed word.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q      <= FILL;
            issued_q     <= {CNT_W{1'b0}};
            captured_q   <= {CNT_W{1'b0}};
            rd_pend_q    <= 1'b0;
            flush_pend_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= {WORD_W{1'b0}};
            out_keep_q   <= {BYTES_PER_WORD{1'b0}};
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            issued_q     <= issued_d;
            captured_q   <= captured_d;
            rd_pend_q    <= rd_pend_d;
            flush_pend_q <= flush_pend_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_keep_q   <= out_keep_d;
            out_last_q   <= out_last_d;
        end
    end

    assign fifo_read = fifo_read_s;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;
    assign out_last  = out_last_q;

endmodule
